pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Fetch/execute control FSM for the TRISC program counter. Drives the active-low inc/clear/load strobes and load data of the N-bit binary up counter used as PC. Runs the instruction-memory fetch handshake and the execute-unit start/done handshake. Keeps a shadow copy of the PC for status and checking.

Parameters:
N, 4, PC width; matches the counter width.
IW, 8, instruction word width.
TIMEOUT, 15, fetch watchdog limit in cycles (used only with FETCH_WDOG_EN).

Ports:
clk  in  1  system clock, rising edge.
clear  in  1  synchronous active-low reset.
run  in  1  level; 1 = allow instruction sequencing.
halt_req  in  1  request to stop at the next instruction boundary.
mem_req  out  1  instruction fetch request.
mem_ack  in  1  fetch complete; instr_in valid in the same cycle.
instr_in  in  IW  fetched instruction.
ir  out  IW  latched instruction register.
ir_valid  out  1  ir holds the current instruction.
exec_start  out  1  one-cycle pulse to the execute unit.
exec_done  in  1  execute unit finished.
branch_taken  in  1  sampled with exec_done.
branch_target  in  N  sampled with exec_done.
pc_clear_n  out  1  to counter clear; active low.
pc_load_n  out  1  to counter load; active low.
pc_inc_n  out  1  to counter inc; active low.
pc_d  out  N  to counter D.
pc_shadow  out  N  expected counter value.
halted  out  1  FSM is in HALT.
fault  out  1  fetch watchdog tripped (tied 0 without FETCH_WDOG_EN).

Behaviour:
- All outputs are registered.
- clear=0 at a rising edge:
  - state INIT; mem_req=0, ir=0, ir_valid=0, exec_start=0.
  - all three strobes=1; pc_d=0, pc_shadow=0, halted=0, fault=0.
  - The pending-halt flag is cleared.
- Reset mid-operation aborts the operation with no strobe and no partial update.
- States: INIT, IDLE, FETCH, EXEC, UPDATE, HALT.
- INIT: pc_clear_n=0 for exactly one cycle, then IDLE.
- IDLE: all strobes high. If run=1, go to FETCH on the next cycle.
- FETCH:
  - mem_req=1 and held until mem_ack=1 is sampled.
  - On ack: ir<=instr_in, ir_valid<=1, mem_req<=0, go to EXEC.
  - mem_ack is ignored in every other state.
  - ir_valid=0 while in FETCH.
- EXEC:
  - exec_start=1 in the first EXEC cycle only.
  - exec_done is sampled in every EXEC cycle, including the first.
  - On exec_done:
    - if branch_taken: pc_d<=branch_target, pc_shadow<=branch_target.
    - else: pc_shadow<=pc_shadow+1 mod 2^N (all-ones wraps to 0).
    - Go to UPDATE.
- UPDATE (exactly one cycle):
  - Exactly one strobe low: pc_load_n=0 if branch, else pc_inc_n=0.
  - pc_d is stable from the cycle before the pulse through the cycle after it, because the counter acts on the falling strobe.
  - Next state:
    - HALT if the halt flag is set.
    - else IDLE if run=0.
    - else FETCH.
- halt_req handling:
  - halt_req=1 in any cycle sets a sticky halt flag.
  - The flag is honoured only at UPDATE exit, or immediately in IDLE.
  - An instruction is never abandoned mid-flight.
- HALT:
  - halted=1, no strobes, mem_req=0.
  - Leaves to IDLE when run=0 and halt_req=0; the halt flag clears on exit.
- Strobe rules:
  - At most one strobe is low in any cycle.
  - Each low pulse is exactly one clk cycle.
  - Consecutive pulses are separated by ≥1 high cycle. This is guaranteed because UPDATE is never adjacent to INIT or another UPDATE.
- Invariant: after each pulse settles, the counter Q equals pc_shadow.
- run dropping mid-instruction has no effect until UPDATE exit.

Optional Feature:
- Macro: FETCH_WDOG_EN.
- When defined:
  - A cycle counter runs while in FETCH, reset on FETCH entry.
  - If mem_ack has not arrived after TIMEOUT cycles in FETCH: mem_req<=0, fault<=1, go to HALT.
  - fault is sticky until clear=0.
  - HALT with fault=1 does not exit on run=0; only reset leaves it.
- When undefined:
  - No counter logic; FETCH waits indefinitely.
  - fault is constant 0.

Test Plan:
- Reset then run=1 (N=4): one cycle with pc_clear_n=0 in INIT; then FETCH with mem_req=1; pc_shadow=0.
- Three sequential instructions (mem_ack after 2 cycles, exec_done 1 cycle after exec_start, branch_taken=0): three single-cycle pc_inc_n pulses, pc_shadow=3, never two strobes low in one cycle.
- Branch: exec_done=1, branch_taken=1, branch_target=4'hA → pc_d=A stable around a one-cycle pc_load_n pulse; pc_shadow=A; the next fetch follows.
- Wrap: pc_shadow=4'hF, non-branch instruction completes → pc_inc_n pulse, pc_shadow=0.
- halt_req pulsed for 1 cycle during EXEC → current instruction completes with its strobe, then HALT with halted=1. run=0 → IDLE, halted=0.
- With FETCH_WDOG_EN, TIMEOUT=15, mem_ack held 0 → after 15 FETCH cycles mem_req=0, fault=1, HALT. run=0 does not exit; clear=0 returns to INIT with fault=0.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Fetch/execute sequencer that drives the active-low strobes of the
//            TRISC PC counter and keeps a shadow PC. FETCH_WDOG_EN adds a fetch
//            watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int N       = 4,
  parameter int IW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          clear_i,
  input  logic          run_i,
  input  logic          halt_req_i,
  output logic          mem_req_o,
  input  logic          mem_ack_i,
  input  logic [IW-1:0] instr_in_i,
  output logic [IW-1:0] ir_o,
  output logic          ir_valid_o,
  output logic          exec_start_o,
  input  logic          exec_done_i,
  input  logic          branch_taken_i,
  input  logic [N-1:0]  branch_target_i,
  output logic          pc_clear_n_o,
  output logic          pc_load_n_o,
  output logic          pc_inc_n_o,
  output logic [N-1:0]  pc_d_o,
  output logic [N-1:0]  pc_shadow_o,
  output logic          halted_o,
  output logic          fault_o
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_FETCH  = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("pc_sequencer: TIMEOUT must be at least 1");
  end

  state_t         state_q, state_d;
  logic           mem_req_q, mem_req_d;
  logic [IW-1:0]  ir_q, ir_d;
  logic           ir_valid_q, ir_valid_d;
  logic           exec_start_q, exec_start_d;
  logic           clear_n_q, clear_n_d;
  logic           load_n_q, load_n_d;
  logic           inc_n_q, inc_n_d;
  logic [N-1:0]   pc_data_q, pc_data_d;
  logic [N-1:0]   shadow_q, shadow_d;
  logic           halted_q, halted_d;
  logic           halt_flag_q, halt_flag_d;
  logic           branch_q, branch_d;
  logic           w_halt_pend;
  logic           w_may_leave_halt;

`ifdef FETCH_WDOG_EN
  localparam int          TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  logic [TW-1:0]  wdog_q, wdog_d;
  logic           fault_q, fault_d;

  assign w_may_leave_halt = !fault_q;
  assign fault_o          = fault_q;
`else
  assign w_may_leave_halt = 1'b1;
  assign fault_o          = 1'b0;
`endif

  // A halt request raised in the deciding cycle itself is honoured too.
  assign w_halt_pend = halt_flag_q | halt_req_i;

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    ir_d         = ir_q;
    ir_valid_d   = ir_valid_q;
    exec_start_d = 1'b0;
    clear_n_d    = 1'b1;
    load_n_d     = 1'b1;
    inc_n_d      = 1'b1;
    pc_data_d    = pc_data_q;
    shadow_d     = shadow_q;
    halted_d     = halted_q;
    halt_flag_d  = w_halt_pend;
    branch_d     = branch_q;
`ifdef FETCH_WDOG_EN
    wdog_d       = '0;
    fault_d      = fault_q;
`endif

    case (state_q)
      S_INIT: begin
        clear_n_d = 1'b0;
        state_d   = S_IDLE;
      end

      S_IDLE: begin
        if (w_halt_pend) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (run_i) begin
          state_d    = S_FETCH;
          mem_req_d  = 1'b1;
          ir_valid_d = 1'b0;
        end
      end

      S_FETCH: begin
        if (mem_ack_i) begin
          ir_d         = instr_in_i;
          ir_valid_d   = 1'b1;
          mem_req_d    = 1'b0;
          exec_start_d = 1'b1;
          state_d      = S_EXEC;
        end
`ifdef FETCH_WDOG_EN
        else if (wdog_q == TLIM) begin
          mem_req_d = 1'b0;
          fault_d   = 1'b1;
          halted_d  = 1'b1;
          state_d   = S_HALT;
        end else begin
          wdog_d = wdog_q + TW'(1);
        end
`endif
      end

      S_EXEC: begin
        if (exec_done_i) begin
          branch_d = branch_taken_i;
          if (branch_taken_i) begin
            pc_data_d = branch_target_i;
            shadow_d  = branch_target_i;
          end else begin
            shadow_d  = shadow_q + N'(1);
          end
          state_d = S_UPDATE;
        end
      end

      // pc_d already settled at EXEC exit, so the registered strobe lands a
      // full cycle after the data and the counter sees stable D on its edge.
      S_UPDATE: begin
        if (branch_q) load_n_d = 1'b0;
        else          inc_n_d  = 1'b0;
        if (w_halt_pend) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (!run_i) begin
          state_d = S_IDLE;
        end else begin
          state_d    = S_FETCH;
          mem_req_d  = 1'b1;
          ir_valid_d = 1'b0;
        end
      end

      S_HALT: begin
        mem_req_d = 1'b0;
        if (!run_i && !halt_req_i && w_may_leave_halt) begin
          state_d     = S_IDLE;
          halted_d    = 1'b0;
          halt_flag_d = 1'b0;
        end
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear_i) begin
      state_q      <= S_INIT;
      mem_req_q    <= 1'b0;
      ir_q         <= '0;
      ir_valid_q   <= 1'b0;
      exec_start_q <= 1'b0;
      clear_n_q    <= 1'b1;
      load_n_q     <= 1'b1;
      inc_n_q      <= 1'b1;
      pc_data_q    <= '0;
      shadow_q     <= '0;
      halted_q     <= 1'b0;
      halt_flag_q  <= 1'b0;
      branch_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      ir_q         <= ir_d;
      ir_valid_q   <= ir_valid_d;
      exec_start_q <= exec_start_d;
      clear_n_q    <= clear_n_d;
      load_n_q     <= load_n_d;
      inc_n_q      <= inc_n_d;
      pc_data_q    <= pc_data_d;
      shadow_q     <= shadow_d;
      halted_q     <= halted_d;
      halt_flag_q  <= halt_flag_d;
      branch_q     <= branch_d;
    end
  end

`ifdef FETCH_WDOG_EN
  always_ff @(posedge clk) begin
    if (!clear_i) begin
      wdog_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      fault_q <= fault_d;
    end
  end
`endif

  assign mem_req_o    = mem_req_q;
  assign ir_o         = ir_q;
  assign ir_valid_o   = ir_valid_q;
  assign exec_start_o = exec_start_q;
  assign pc_clear_n_o = clear_n_q;
  assign pc_load_n_o  = load_n_q;
  assign pc_inc_n_o   = inc_n_q;
  assign pc_d_o       = pc_data_q;
  assign pc_shadow_o  = shadow_q;
  assign halted_o     = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer with an instruction-level
//            reference model and a model of the external PC counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;
  localparam int N  = 4;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          clear_i, run_i, halt_req_i, mem_ack_i, exec_done_i, branch_taken_i;
  logic [IW-1:0] instr_in_i, ir_o;
  logic [N-1:0]  branch_target_i, pc_d_o, pc_shadow_o;
  logic          mem_req_o, ir_valid_o, exec_start_o;
  logic          pc_clear_n_o, pc_load_n_o, pc_inc_n_o, halted_o, fault_o;

  int            n_chk  = 0;
  int            n_fail = 0;
  logic [N-1:0]  exp_shadow;
  logic [N-1:0]  cnt_model;
  bit            mon_en = 1'b0;
  bit            any_low_prev = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer #(.N(N), .IW(IW), .TIMEOUT(15)) dut (
    .clk(clk), .clear_i(clear_i), .run_i(run_i), .halt_req_i(halt_req_i),
    .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i), .instr_in_i(instr_in_i),
    .ir_o(ir_o), .ir_valid_o(ir_valid_o), .exec_start_o(exec_start_o),
    .exec_done_i(exec_done_i), .branch_taken_i(branch_taken_i),
    .branch_target_i(branch_target_i), .pc_clear_n_o(pc_clear_n_o),
    .pc_load_n_o(pc_load_n_o), .pc_inc_n_o(pc_inc_n_o), .pc_d_o(pc_d_o),
    .pc_shadow_o(pc_shadow_o), .halted_o(halted_o), .fault_o(fault_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The external counter acts on the falling edge of each strobe.
  always @(negedge pc_clear_n_o or negedge pc_load_n_o or negedge pc_inc_n_o) begin
    if (!pc_clear_n_o)     cnt_model = '0;
    else if (!pc_load_n_o) cnt_model = pc_d_o;
    else if (!pc_inc_n_o)  cnt_model = cnt_model + N'(1);
  end

  always @(negedge clk) begin
    int lows;
    if (mon_en) begin
      lows = int'(!pc_clear_n_o) + int'(!pc_load_n_o) + int'(!pc_inc_n_o);
      if (lows != 0) begin
        chk("one_strobe", 32'(lows), 32'd1);
        chk("strobe_gap", 32'(any_low_prev), 32'd0);
      end
      any_low_prev = (lows != 0);
    end
  end

  // One complete instruction; returns two cycles after the UPDATE decision.
  task automatic run_instr(input int ack_dly, input int done_dly, input bit br,
                           input logic [N-1:0] tgt, input bit hreq, input bit drop);
    logic [IW-1:0] instr;
    int guard;
    guard = 0;
    while (mem_req_o !== 1'b1 && guard < 30) begin
      tick();
      guard++;
    end
    chk("fetch_req", 32'(mem_req_o), 32'd1);
    chk("ir_valid_fetch", 32'(ir_valid_o), 32'd0);
    repeat (ack_dly) tick();
    chk("req_held", 32'(mem_req_o), 32'd1);
    chk("no_fault", 32'(fault_o), 32'd0);
    instr      = IW'($urandom);
    mem_ack_i  = 1'b1;
    instr_in_i = instr;
    tick();
    mem_ack_i  = 1'b0;
    instr_in_i = IW'($urandom);
    chk("exec_start", 32'(exec_start_o), 32'd1);
    chk("ir", 32'(ir_o), 32'(instr));
    chk("ir_valid", 32'(ir_valid_o), 32'd1);
    chk("req_drop", 32'(mem_req_o), 32'd0);
    if (hreq) halt_req_i = 1'b1;
    if (drop) run_i = 1'b0;
    if (done_dly > 0) begin
      tick();
      halt_req_i = 1'b0;
      chk("start_pulse", 32'(exec_start_o), 32'd0);
      repeat (done_dly - 1) tick();
    end
    exec_done_i     = 1'b1;
    branch_taken_i  = br;
    branch_target_i = tgt;
    tick();
    exec_done_i     = 1'b0;
    halt_req_i      = 1'b0;
    branch_taken_i  = 1'($urandom_range(0, 1));
    branch_target_i = N'($urandom);
    exp_shadow = br ? tgt : exp_shadow + N'(1);
    chk("shadow_upd", 32'(pc_shadow_o), 32'(exp_shadow));
    chk("setup_load", 32'(pc_load_n_o), 32'd1);
    chk("setup_inc", 32'(pc_inc_n_o), 32'd1);
    if (br) chk("pc_d_before", 32'(pc_d_o), 32'(tgt));
    tick();
    chk("pulse_load", 32'(pc_load_n_o), 32'(!br));
    chk("pulse_inc", 32'(pc_inc_n_o), 32'(br));
    chk("pulse_clear", 32'(pc_clear_n_o), 32'd1);
    chk("halted_pulse", 32'(halted_o), 32'(hreq));
    chk("next_req", 32'(mem_req_o), 32'(!hreq && !drop));
    if (br) chk("pc_d_during", 32'(pc_d_o), 32'(tgt));
    tick();
    chk("after_load", 32'(pc_load_n_o), 32'd1);
    chk("after_inc", 32'(pc_inc_n_o), 32'd1);
    if (br) chk("pc_d_after", 32'(pc_d_o), 32'(tgt));
    chk("counter_eq", 32'(cnt_model), 32'(exp_shadow));
    if (drop && !hreq) begin
      chk("idle_no_req", 32'(mem_req_o), 32'd0);
      run_i = 1'b1;
    end
    if (hreq) begin
      chk("halted", 32'(halted_o), 32'd1);
      chk("halt_no_req", 32'(mem_req_o), 32'd0);
      repeat (2) tick();
      chk("halt_stays", 32'(halted_o), 32'd1);
      run_i = 1'b0;
      tick();
      chk("halt_exit", 32'(halted_o), 32'd0);
      run_i = 1'b1;
    end
  endtask

  initial begin
    bit hr, dr;
    clear_i = 1'b0; run_i = 1'b0; halt_req_i = 1'b0; mem_ack_i = 1'b0;
    instr_in_i = '0; exec_done_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = '0;
    repeat (3) tick();
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_ir", 32'(ir_o), 32'd0);
    chk("rst_ir_valid", 32'(ir_valid_o), 32'd0);
    chk("rst_exec_start", 32'(exec_start_o), 32'd0);
    chk("rst_strobes", {29'd0, pc_clear_n_o, pc_load_n_o, pc_inc_n_o}, 32'd7);
    chk("rst_pc_d", 32'(pc_d_o), 32'd0);
    chk("rst_shadow", 32'(pc_shadow_o), 32'd0);
    chk("rst_halted", 32'(halted_o), 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);

    clear_i = 1'b1;
    run_i   = 1'b1;
    mon_en  = 1'b1;
    tick();
    chk("init_clear", 32'(pc_clear_n_o), 32'd0);
    chk("init_no_req", 32'(mem_req_o), 32'd0);
    tick();
    chk("init_clear_end", 32'(pc_clear_n_o), 32'd1);
    chk("first_fetch", 32'(mem_req_o), 32'd1);
    chk("first_shadow", 32'(pc_shadow_o), 32'd0);
    chk("counter_cleared", 32'(cnt_model), 32'd0);
    exp_shadow = '0;

    repeat (3) run_instr(2, 1, 1'b0, '0, 1'b0, 1'b0);
    chk("three_seq", 32'(pc_shadow_o), 32'd3);

    run_instr(1, 0, 1'b1, 4'hA, 1'b0, 1'b0);
    chk("branch_A", 32'(pc_shadow_o), 32'hA);

    run_instr(0, 0, 1'b1, 4'hF, 1'b0, 1'b0);
    run_instr(0, 2, 1'b0, '0, 1'b0, 1'b0);
    chk("wrap", 32'(pc_shadow_o), 32'd0);

    run_instr(1, 1, 1'b0, '0, 1'b1, 1'b0);
    run_instr(0, 0, 1'b0, '0, 1'b1, 1'b0);
    run_instr(1, 2, 1'b0, '0, 1'b0, 1'b1);

`ifndef FETCH_WDOG_EN
    run_instr(20, 1, 1'b1, 4'h5, 1'b0, 1'b0);
`endif

    for (int k = 0; k < 40; k++) begin
      hr = ($urandom_range(0, 7) == 0);
      dr = !hr && ($urandom_range(0, 7) == 0);
      run_instr($urandom_range(0, 4), $urandom_range(0, 3),
                ($urandom_range(0, 2) == 0), N'($urandom), hr, dr);
    end

    // Reset in the middle of EXEC: no strobe, no partial update.
    while (mem_req_o !== 1'b1 && n_chk < 100000) tick();
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    exec_done_i = 1'b1;
    clear_i = 1'b0;
    tick();
    exec_done_i = 1'b0;
    chk("midrst_req", 32'(mem_req_o), 32'd0);
    chk("midrst_valid", 32'(ir_valid_o), 32'd0);
    chk("midrst_shadow", 32'(pc_shadow_o), 32'd0);
    chk("midrst_strobes", {29'd0, pc_clear_n_o, pc_load_n_o, pc_inc_n_o}, 32'd7);
    clear_i = 1'b1;
    tick();
    chk("midrst_clear", 32'(pc_clear_n_o), 32'd0);
    tick();
    chk("midrst_counter", 32'(cnt_model), 32'd0);
    exp_shadow = '0;
    run_instr(0, 0, 1'b0, '0, 1'b0, 1'b0);

`ifdef FETCH_WDOG_EN
    begin
      int guard;
      guard = 0;
      while (mem_req_o !== 1'b1 && guard < 30) begin
        tick();
        guard++;
      end
      chk("wd_fetch", 32'(mem_req_o), 32'd1);
      repeat (14) tick();
      chk("wd_still_req", 32'(mem_req_o), 32'd1);
      chk("wd_no_fault_yet", 32'(fault_o), 32'd0);
      tick();
      chk("wd_req_drop", 32'(mem_req_o), 32'd0);
      chk("wd_fault", 32'(fault_o), 32'd1);
      chk("wd_halted", 32'(halted_o), 32'd1);
      run_i = 1'b0;
      repeat (3) tick();
      chk("wd_stuck_halt", 32'(halted_o), 32'd1);
      chk("wd_stuck_fault", 32'(fault_o), 32'd1);
      clear_i = 1'b0;
      tick();
      chk("wd_rst_fault", 32'(fault_o), 32'd0);
      chk("wd_rst_halted", 32'(halted_o), 32'd0);
      clear_i = 1'b1;
      tick();
      chk("wd_init_clear", 32'(pc_clear_n_o), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
